cnt_prescaled_mod: RTL and testbench

CNT_PRESCALED_MOD -- requirements
Module: cnt_prescaled_mod

---
 rtl/cnt_prescaled_mod.sv | 100 ++++++++++
 tb/tb_cnt_prescaled_mod.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_prescaled_mod.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_prescaled_mod
//  Brief    : Modulo counter stepped by a clock-enable prescaler; optional
//             down-counting compiled in with macro CNT_UPDOWN_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module cnt_prescaled_mod #(
    parameter int WIDTH    = 7,
    parameter int COUNT_TO = 60,
    parameter int DIV      = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc
);

    localparam int               PS_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(COUNT_TO - 1);

    logic [PS_W-1:0]  ps_q,   ps_d;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic             tick_q, tick_d;
    logic             tc_q,   tc_d;
    logic             w_up;
    logic             w_step;

`ifdef CNT_UPDOWN_EN
    assign w_up = dir;
`else
    logic w_unused_dir;
    assign w_up         = 1'b1;
    assign w_unused_dir = dir;
`endif

    always_comb begin
        ps_d   = ps_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        w_step = en && (ps_q == PS_LAST);

        if (clr) begin
            ps_d  = '0;
            cnt_d = '0;
        end else if (load) begin
            // Out-of-range load values collapse to zero so the count never leaves 0..COUNT_TO-1
            ps_d  = '0;
            cnt_d = (load_val <= CNT_LAST) ? load_val : '0;
        end else if (w_step) begin
            ps_d   = '0;
            tick_d = 1'b1;
            if (w_up) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_LAST;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end else if (en) begin
            ps_d = ps_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q   <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign out  = cnt_q;
    assign tick = tick_q;
    assign tc   = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_prescaled_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnt_prescaled_mod
//  Brief    : Scoreboarded bench for cnt_prescaled_mod (7/60/50 and 3/4/1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_prescaled_mod;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, dir_a, dir_b;
    logic [6:0] lv_a;
    logic [2:0] lv_b;
    logic [6:0] out_a;
    logic       tick_a, tc_a;
    logic [2:0] out_b;
    logic       tick_b, tc_b;

    always #5 clk = ~clk;
    assign lv_b = lv_a[2:0];

    cnt_prescaled_mod #(.WIDTH(7), .COUNT_TO(60), .DIV(50)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv_a),
        .dir(dir_a), .out(out_a), .tick(tick_a), .tc(tc_a)
    );

    cnt_prescaled_mod #(.WIDTH(3), .COUNT_TO(4), .DIV(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv_b),
        .dir(dir_b), .out(out_b), .tick(tick_b), .tc(tc_b)
    );

    typedef struct packed {
        logic [6:0] oa;
        logic       ta;
        logic       ca;
        logic [2:0] ob;
        logic       tb;
        logic       cb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ps_a, m_cnt_a, m_ps_b, m_cnt_b;
    int   n_tick_a, n_tc_a;
    int   exp_b[4];
    int   exp_tcb[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Reference behaviour: priority clr > load > enabled prescale step
    task automatic mstep(input int div, input int cto, input bit up, input int lv,
                         inout int ps, inout int cnt, output bit tk, output bit t);
        tk = 1'b0;
        t  = 1'b0;
        if (clr) begin
            ps  = 0;
            cnt = 0;
        end else if (load) begin
            ps  = 0;
            cnt = (lv < cto) ? lv : 0;
        end else if (en) begin
            ps = ps + 1;
            if (ps == div) begin
                ps = 0;
                tk = 1'b1;
                if (up) begin
                    cnt = cnt + 1;
                    if (cnt == cto) begin
                        cnt = 0;
                        t   = 1'b1;
                    end
                end else begin
                    cnt = cnt - 1;
                    if (cnt < 0) begin
                        cnt = cto - 1;
                        t   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        exp_t e;
        bit   up_a, up_b, tk, t;
`ifdef CNT_UPDOWN_EN
        up_a = dir_a;
        up_b = dir_b;
`else
        up_a = 1'b1;
        up_b = 1'b1;
`endif
        e = '0;
        if (!rst) begin
            m_ps_a = 0; m_cnt_a = 0; m_ps_b = 0; m_cnt_b = 0;
        end else begin
            mstep(50, 60, up_a, int'(lv_a), m_ps_a, m_cnt_a, tk, t);
            e.ta = tk;
            e.ca = t;
            mstep(1, 4, up_b, int'(lv_b), m_ps_b, m_cnt_b, tk, t);
            e.tb = tk;
            e.cb = t;
            e.oa = 7'(m_cnt_a);
            e.ob = 3'(m_cnt_b);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_a", {out_a, tick_a, tc_a}, {e.oa, e.ta, e.ca});
        chk("sb_b", {out_b, tick_b, tc_b}, {e.ob, e.tb, e.cb});
        n_tick_a += int'(tick_a);
        n_tc_a   += int'(tc_a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b1; lv_a = 7'd42;
        dir_a = 1'b1; dir_b = 1'b0;
        m_ps_a = 0; m_cnt_a = 0; m_ps_b = 0; m_cnt_b = 0;
`ifdef CNT_UPDOWN_EN
        exp_b   = '{3, 2, 1, 0};
        exp_tcb = '{1, 0, 0, 0};
`else
        exp_b   = '{1, 2, 3, 0};
        exp_tcb = '{0, 0, 0, 1};
`endif

        // reset held: clock and active inputs are ignored
        repeat (3) cyc();
        chk("reset_hold", {out_a, tick_a, tc_a}, 32'd0);

        rst = 1'b1; load = 1'b0; lv_a = 7'd0;
        n_tick_a = 0; n_tc_a = 0;
        for (int i = 1; i <= 3000; i++) begin
            cyc();
            if (i <= 4) begin
                chk("b_seq_out", out_b, exp_b[i-1]);
                chk("b_seq_tc", tc_b, exp_tcb[i-1]);
            end
            if (i == 49) chk("pre_first_tick", {out_a, tick_a}, {7'd0, 1'b0});
            if (i == 50) chk("first_tick", {out_a, tick_a}, {7'd1, 1'b1});
            if (i == 2999) chk("pre_wrap", {out_a, tc_a}, {7'd59, 1'b0});
            if (i == 3000) chk("wrap_a", {out_a, tc_a}, {7'd0, 1'b1});
        end
        chk("tick_count", n_tick_a, 60);
        chk("tc_count", n_tc_a, 1);

        // load: out of range then in range, then one full prescale period
        load = 1'b1; lv_a = 7'd75;
        cyc();
        chk("load_oor", out_a, 0);
        lv_a = 7'd42;
        cyc();
        chk("load_ok", out_a, 42);
        load = 1'b0;
        repeat (49) cyc();
        chk("load_hold", {out_a, tick_a}, {7'd42, 1'b0});
        cyc();
        chk("load_next", {out_a, tick_a}, {7'd43, 1'b1});

        // freeze 20 clocks at prescaler=30
        repeat (30) cyc();
        en = 1'b0;
        repeat (20) cyc();
        chk("frozen", {out_a, tick_a}, {7'd43, 1'b0});
        en = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick_a && n < 100);
        chk("resume_gap", n, 20);
        chk("resume_out", out_a, 44);

        // clr and load together on a would-be tick at 59
        load = 1'b1; lv_a = 7'd59;
        cyc();
        load = 1'b0;
        repeat (49) cyc();
        clr = 1'b1; load = 1'b1; lv_a = 7'd10;
        cyc();
        chk("clr_load", {out_a, tick_a, tc_a}, 32'd0);
        clr = 1'b0; load = 1'b0;
        repeat (49) cyc();
        chk("clr_ps_hold", {out_a, tick_a}, {7'd0, 1'b0});
        cyc();
        chk("clr_ps_tick", {out_a, tick_a}, {7'd1, 1'b1});

        // load wins over a coincident tick
        load = 1'b1; lv_a = 7'd59;
        cyc();
        load = 1'b0;
        repeat (49) cyc();
        load = 1'b1; lv_a = 7'd5;
        cyc();
        chk("load_prio", {out_a, tick_a, tc_a}, {7'd5, 1'b0, 1'b0});
        load = 1'b0;

        // direction changed mid-period takes effect at the next tick
        load = 1'b1; lv_a = 7'd10;
        cyc();
        load = 1'b0;
        repeat (20) cyc();
        dir_a = 1'b0;
        repeat (29) cyc();
        chk("dir_mid", out_a, 10);
        cyc();
`ifdef CNT_UPDOWN_EN
        chk("dir_step", out_a, 9);
`else
        chk("dir_step", out_a, 11);
`endif

        // down-count wrap from zero
        load = 1'b1; lv_a = 7'd0;
        cyc();
        load = 1'b0;
        repeat (50) cyc();
`ifdef CNT_UPDOWN_EN
        chk("down_wrap", {out_a, tc_a}, {7'd59, 1'b1});
`else
        chk("down_wrap", {out_a, tc_a}, {7'd1, 1'b0});
`endif
        dir_a = 1'b1;

        // asynchronous reset mid-count, then a full period after release
        load = 1'b1; lv_a = 7'd17;
        cyc();
        load = 1'b0;
        repeat (10) cyc();
        chk("pre_rst", out_a, 17);
        #3 rst = 1'b0;
        #1;
        chk("async_rst", {out_a, tick_a, tc_a, out_b}, 32'd0);
        repeat (2) cyc();
        rst = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick_a && n < 200);
        chk("post_rst_gap", n, 50);
        chk("post_rst_out", out_a, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
